// File: rtl/line_ptr_manager.sv
// Pointer and flag manager for a line-organised packet buffer: RAM addresses,
// occupancy flags, and per-line length/tlast storage with overflow discard.
module line_ptr_manager #(
  parameter int CHAR_W      = 8,
  parameter int LINE_W      = 5,
  parameter int AFULL_LINES = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_char_incr,
  input  logic                     wr_newline,
  input  logic                     wr_restart_line,
  input  logic                     wr_tlast,
  input  logic                     rd_char_incr,
  input  logic                     rd_newline,
  input  logic                     rd_restart_line,
  output logic [LINE_W+CHAR_W-1:0] wr_ptr,
  output logic [LINE_W+CHAR_W-1:0] rd_ptr,
  output logic                     wr_greenflag,
  output logic                     rd_greenflag,
  output logic                     wr_afull,
  output logic [LINE_W:0]          used_lines,
  output logic                     tlast_flag,
  output logic [CHAR_W:0]          rd_line_len,
  output logic                     rd_last_char,
  output logic                     wr_drop
);

  localparam int NLINES = 1 << LINE_W;
  localparam logic [CHAR_W:0]   CNT_MAX     = (CHAR_W+1)'(1 << CHAR_W);
  localparam logic [CHAR_W:0]   CNT_ONE     = (CHAR_W+1)'(1);
  localparam logic [CHAR_W:0]   CNT_ZERO    = (CHAR_W+1)'(0);
  localparam logic [LINE_W:0]   LINE_ONE    = (LINE_W+1)'(1);
  localparam logic [LINE_W:0]   LINE_ZERO   = (LINE_W+1)'(0);
  localparam logic [LINE_W:0]   FULL_CNT    = (LINE_W+1)'(NLINES);
  localparam logic [LINE_W:0]   AFULL_CNT   = (LINE_W+1)'(AFULL_LINES);
  localparam logic [CHAR_W-1:0] RD_CHAR_MAX = {CHAR_W{1'b1}};
  localparam logic [CHAR_W-1:0] RD_CHAR_0   = {CHAR_W{1'b0}};

  logic [LINE_W:0]   wl_r;
  logic [LINE_W:0]   rl_r;
  logic [CHAR_W:0]   wcnt_r;
  logic [CHAR_W-1:0] rd_char_r;
  logic              ovf_r;
  logic              wr_drop_r;

  logic [CHAR_W:0]   len_mem [NLINES];
  logic              tlast_mem [NLINES];

  logic [LINE_W:0]   used_s;
  logic              wr_green_s;
  logic              rd_green_s;
  logic              wr_acc_s;
  logic              ovf_set_s;
  logic [CHAR_W:0]   commit_len_s;
  logic              do_drop_s;
  logic              do_commit_s;
  logic [CHAR_W:0]   len_rd_s;
  logic              tlast_rd_s;

  assign used_s     = wl_r - rl_r;
  assign rd_green_s = (used_s != LINE_ZERO);
  assign wr_green_s = (used_s != FULL_CNT);

  // Write-side decode: character acceptance, overflow, commit/discard choice
  always_comb begin
    wr_acc_s  = 1'b0;
    ovf_set_s = 1'b0;
    if (wr_char_incr && wr_green_s) begin
      if (wcnt_r == CNT_MAX) begin
        ovf_set_s = 1'b1;
      end else begin
        wr_acc_s = 1'b1;
      end
    end else begin
      wr_acc_s  = 1'b0;
      ovf_set_s = 1'b0;
    end

    // A character arriving with the commit belongs to the committed line
    commit_len_s = wcnt_r + (wr_acc_s ? CNT_ONE : CNT_ZERO);

    do_drop_s   = 1'b0;
    do_commit_s = 1'b0;
    if (wr_restart_line) begin
      do_drop_s   = 1'b0;
      do_commit_s = 1'b0;
    end else if (wr_newline && (ovf_r || ovf_set_s)) begin
      do_drop_s = 1'b1;
    end else if (wr_newline && wr_green_s && (commit_len_s != CNT_ZERO)) begin
      do_commit_s = 1'b1;
    end else begin
      do_drop_s   = 1'b0;
      do_commit_s = 1'b0;
    end
  end

  // Write line/character counters, overflow latch and drop pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wl_r      <= LINE_ZERO;
      wcnt_r    <= CNT_ZERO;
      ovf_r     <= 1'b0;
      wr_drop_r <= 1'b0;
    end else begin
      wr_drop_r <= do_drop_s;
      if (do_commit_s) begin
        wl_r <= wl_r + LINE_ONE;
      end
      if (wr_restart_line || do_drop_s || do_commit_s) begin
        wcnt_r <= CNT_ZERO;
        ovf_r  <= 1'b0;
      end else begin
        if (wr_acc_s) begin
          wcnt_r <= wcnt_r + CNT_ONE;
        end
        if (ovf_set_s) begin
          ovf_r <= 1'b1;
        end
      end
    end
  end

  // Per-line length and tlast storage; unread contents are masked by rd_greenflag
  always_ff @(posedge clk) begin
    if (do_commit_s) begin
      len_mem[wl_r[LINE_W-1:0]]   <= commit_len_s;
      tlast_mem[wl_r[LINE_W-1:0]] <= wr_tlast;
    end
  end

  // Read line/character counters; newline beats restart beats increment
  always_ff @(posedge clk) begin
    if (rst) begin
      rl_r      <= LINE_ZERO;
      rd_char_r <= RD_CHAR_0;
    end else if (rd_green_s) begin
      if (rd_newline) begin
        rl_r      <= rl_r + LINE_ONE;
        rd_char_r <= RD_CHAR_0;
      end else if (rd_restart_line) begin
        rd_char_r <= RD_CHAR_0;
      end else if (rd_char_incr && (rd_char_r != RD_CHAR_MAX)) begin
        rd_char_r <= rd_char_r + {{(CHAR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign len_rd_s   = len_mem[rl_r[LINE_W-1:0]];
  assign tlast_rd_s = tlast_mem[rl_r[LINE_W-1:0]];

  assign wr_ptr       = {wl_r[LINE_W-1:0], wcnt_r[CHAR_W-1:0]};
  assign rd_ptr       = {rl_r[LINE_W-1:0], rd_char_r};
  assign wr_greenflag = wr_green_s;
  assign rd_greenflag = rd_green_s;
  assign wr_afull     = (used_s >= AFULL_CNT);
  assign used_lines   = used_s;
  assign tlast_flag   = rd_green_s & tlast_rd_s;
  assign rd_line_len  = rd_green_s ? len_rd_s : CNT_ZERO;
  assign rd_last_char = rd_green_s & (({1'b0, rd_char_r} + CNT_ONE) == rd_line_len);
  assign wr_drop      = wr_drop_r;

endmodule

// File: tb/tb_line_ptr_manager.sv
// Directed bench for line_ptr_manager with CHAR_W=3, LINE_W=2, AFULL_LINES=3.
module tb_line_ptr_manager;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_char_incr, wr_newline, wr_restart_line, wr_tlast;
  logic       rd_char_incr, rd_newline, rd_restart_line;
  logic [4:0] wr_ptr, rd_ptr;
  logic       wr_greenflag, rd_greenflag, wr_afull;
  logic [2:0] used_lines;
  logic       tlast_flag;
  logic [3:0] rd_line_len;
  logic       rd_last_char, wr_drop;

  int total = 0;
  int bad   = 0;

  line_ptr_manager #(.CHAR_W(3), .LINE_W(2), .AFULL_LINES(3)) dut (
    .clk(clk), .rst(rst),
    .wr_char_incr(wr_char_incr), .wr_newline(wr_newline),
    .wr_restart_line(wr_restart_line), .wr_tlast(wr_tlast),
    .rd_char_incr(rd_char_incr), .rd_newline(rd_newline),
    .rd_restart_line(rd_restart_line),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .wr_greenflag(wr_greenflag), .rd_greenflag(rd_greenflag),
    .wr_afull(wr_afull), .used_lines(used_lines), .tlast_flag(tlast_flag),
    .rd_line_len(rd_line_len), .rd_last_char(rd_last_char), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  // One clock with the currently driven strobes, then sample and clear them
  task automatic tick();
    @(posedge clk);
    #1;
    wr_char_incr = 1'b0; wr_newline = 1'b0; wr_restart_line = 1'b0; wr_tlast = 1'b0;
    rd_char_incr = 1'b0; rd_newline = 1'b0; rd_restart_line = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    total++; if (wr_greenflag !== 1'b1) begin bad++; $display("FAIL reset_wr_green: got %0b want 1", wr_greenflag); end
    total++; if (rd_greenflag !== 1'b0) begin bad++; $display("FAIL reset_rd_green: got %0b want 0", rd_greenflag); end
    total++; if (used_lines !== 3'd0) begin bad++; $display("FAIL reset_used: got %0d want 0", used_lines); end
    total++; if (wr_ptr !== 5'h00) begin bad++; $display("FAIL reset_wr_ptr: got %0h want 0", wr_ptr); end
    total++; if (rd_ptr !== 5'h00) begin bad++; $display("FAIL reset_rd_ptr: got %0h want 0", rd_ptr); end
    total++; if ({wr_afull, tlast_flag, rd_last_char, wr_drop} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {wr_afull, tlast_flag, rd_last_char, wr_drop}); end
    total++; if (rd_line_len !== 4'd0) begin bad++; $display("FAIL reset_len: got %0d want 0", rd_line_len); end
  endtask

  task automatic test_basic_line();
    for (int i = 0; i < 5; i++) begin wr_char_incr = 1'b1; tick(); end
    wr_newline = 1'b1; wr_tlast = 1'b1; tick();
    total++; if (wr_ptr !== 5'h08) begin bad++; $display("FAIL basic_wr_ptr: got %0h want 08", wr_ptr); end
    total++; if (used_lines !== 3'd1) begin bad++; $display("FAIL basic_used: got %0d want 1", used_lines); end
    total++; if (rd_line_len !== 4'd5) begin bad++; $display("FAIL basic_len: got %0d want 5", rd_line_len); end
    total++; if (tlast_flag !== 1'b1) begin bad++; $display("FAIL basic_tlast: got %0b want 1", tlast_flag); end
    for (int i = 0; i < 3; i++) begin rd_char_incr = 1'b1; tick(); end
    total++; if (rd_last_char !== 1'b0) begin bad++; $display("FAIL basic_last_early: got %0b want 0", rd_last_char); end
    rd_char_incr = 1'b1; tick();
    total++; if (rd_ptr !== 5'h04) begin bad++; $display("FAIL basic_rd_ptr: got %0h want 04", rd_ptr); end
    total++; if (rd_last_char !== 1'b1) begin bad++; $display("FAIL basic_last: got %0b want 1", rd_last_char); end
    rd_newline = 1'b1; tick();
    total++; if (rd_ptr !== 5'h08) begin bad++; $display("FAIL basic_rel_ptr: got %0h want 08", rd_ptr); end
    total++; if (rd_greenflag !== 1'b0) begin bad++; $display("FAIL basic_rel_green: got %0b want 0", rd_greenflag); end
    total++; if ({tlast_flag, rd_line_len} !== 5'd0) begin bad++; $display("FAIL basic_gated: got %0h want 0", {tlast_flag, rd_line_len}); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_char_incr = 1'b1; tick();
      wr_char_incr = 1'b1; tick();
      wr_newline = 1'b1; tick();
      if (i == 1) begin
        total++; if (wr_afull !== 1'b0) begin bad++; $display("FAIL fill_afull_2: got %0b want 0", wr_afull); end
      end else if (i == 2) begin
        total++; if (wr_afull !== 1'b1) begin bad++; $display("FAIL fill_afull_3: got %0b want 1", wr_afull); end
        total++; if (wr_greenflag !== 1'b1) begin bad++; $display("FAIL fill_green_3: got %0b want 1", wr_greenflag); end
      end else if (i == 3) begin
        total++; if (wr_greenflag !== 1'b0) begin bad++; $display("FAIL fill_green_4: got %0b want 0", wr_greenflag); end
        total++; if (used_lines !== 3'd4) begin bad++; $display("FAIL fill_used_4: got %0d want 4", used_lines); end
      end
    end
    wr_char_incr = 1'b1; tick();
    wr_char_incr = 1'b1; tick();
    wr_newline = 1'b1; tick();
    total++; if (wr_ptr !== 5'h00) begin bad++; $display("FAIL fill_full_ptr: got %0h want 00", wr_ptr); end
    total++; if (used_lines !== 3'd4) begin bad++; $display("FAIL fill_full_used: got %0d want 4", used_lines); end
    total++; if (rd_line_len !== 4'd2) begin bad++; $display("FAIL fill_len: got %0d want 2", rd_line_len); end
  endtask

  task automatic test_back_to_back();
    rd_newline = 1'b1; wr_newline = 1'b1; wr_char_incr = 1'b1; tick();
    total++; if (used_lines !== 3'd3) begin bad++; $display("FAIL b2b_full_used: got %0d want 3", used_lines); end
    total++; if (wr_ptr !== 5'h00) begin bad++; $display("FAIL b2b_full_wr_ptr: got %0h want 00", wr_ptr); end
    total++; if (rd_ptr !== 5'h08) begin bad++; $display("FAIL b2b_full_rd_ptr: got %0h want 08", rd_ptr); end
    rd_newline = 1'b1; tick();
    wr_char_incr = 1'b1; tick();
    total++; if (wr_ptr !== 5'h01) begin bad++; $display("FAIL b2b_char: got %0h want 01", wr_ptr); end
    wr_newline = 1'b1; rd_newline = 1'b1; tick();
    total++; if (used_lines !== 3'd2) begin bad++; $display("FAIL b2b_used: got %0d want 2", used_lines); end
    total++; if ({wr_ptr, rd_ptr} !== {5'h08, 5'h18}) begin bad++; $display("FAIL b2b_ptrs: got %0h/%0h want 08/18", wr_ptr, rd_ptr); end
    total++; if (rd_line_len !== 4'd2) begin bad++; $display("FAIL b2b_len: got %0d want 2", rd_line_len); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin wr_char_incr = 1'b1; tick(); end
    wr_newline = 1'b1; tick();
    total++; if (wr_drop !== 1'b1) begin bad++; $display("FAIL ovf_drop: got %0b want 1", wr_drop); end
    total++; if (used_lines !== 3'd0) begin bad++; $display("FAIL ovf_used: got %0d want 0", used_lines); end
    total++; if (wr_ptr !== 5'h00) begin bad++; $display("FAIL ovf_wr_ptr: got %0h want 00", wr_ptr); end
    tick();
    total++; if (wr_drop !== 1'b0) begin bad++; $display("FAIL ovf_drop_pulse: got %0b want 0", wr_drop); end
    for (int i = 0; i < 8; i++) begin wr_char_incr = 1'b1; tick(); end
    wr_newline = 1'b1; tick();
    total++; if (used_lines !== 3'd1) begin bad++; $display("FAIL ovf8_used: got %0d want 1", used_lines); end
    total++; if (rd_line_len !== 4'd8) begin bad++; $display("FAIL ovf8_len: got %0d want 8", rd_line_len); end
    total++; if ({wr_ptr, wr_drop} !== {5'h08, 1'b0}) begin bad++; $display("FAIL ovf8_ptr_drop: got %0h/%0b want 08/0", wr_ptr, wr_drop); end
  endtask

  task automatic test_restart();
    for (int i = 0; i < 3; i++) begin rd_char_incr = 1'b1; tick(); end
    total++; if (rd_ptr !== 5'h03) begin bad++; $display("FAIL rrs_pre: got %0h want 03", rd_ptr); end
    rd_restart_line = 1'b1; rd_char_incr = 1'b1; tick();
    total++; if (rd_ptr !== 5'h00) begin bad++; $display("FAIL rrs_ptr: got %0h want 00", rd_ptr); end
    total++; if (used_lines !== 3'd1) begin bad++; $display("FAIL rrs_used: got %0d want 1", used_lines); end
    for (int i = 0; i < 3; i++) begin wr_char_incr = 1'b1; tick(); end
    total++; if (wr_ptr !== 5'h0B) begin bad++; $display("FAIL wrs_pre: got %0h want 0b", wr_ptr); end
    wr_restart_line = 1'b1; wr_newline = 1'b1; tick();
    total++; if (wr_ptr !== 5'h08) begin bad++; $display("FAIL wrs_ptr: got %0h want 08", wr_ptr); end
    total++; if ({used_lines, wr_drop} !== {3'd1, 1'b0}) begin bad++; $display("FAIL wrs_used_drop: got %0d/%0b want 1/0", used_lines, wr_drop); end
    wr_char_incr = 1'b1; tick();
    wr_char_incr = 1'b1; tick();
    wr_char_incr = 1'b1; wr_newline = 1'b1; tick();
    total++; if ({used_lines, wr_ptr} !== {3'd2, 5'h10}) begin bad++; $display("FAIL same_cycle_commit: got %0d/%0h want 2/10", used_lines, wr_ptr); end
    rd_newline = 1'b1; tick();
    total++; if (rd_line_len !== 4'd3) begin bad++; $display("FAIL same_cycle_len: got %0d want 3", rd_line_len); end
    total++; if ({rd_ptr, tlast_flag} !== {5'h08, 1'b0}) begin bad++; $display("FAIL line1_ptr_tlast: got %0h/%0b want 08/0", rd_ptr, tlast_flag); end
    rd_char_incr = 1'b1; tick();
    rd_char_incr = 1'b1; tick();
    total++; if ({rd_ptr, rd_last_char} !== {5'h0A, 1'b1}) begin bad++; $display("FAIL line1_last: got %0h/%0b want 0a/1", rd_ptr, rd_last_char); end
  endtask

  task automatic test_reset_mid();
    wr_char_incr = 1'b1; tick();
    wr_char_incr = 1'b1; tick();
    rd_char_incr = 1'b1; tick();
    rst = 1'b1; wr_char_incr = 1'b1; tick();
    rst = 1'b0;
    total++; if ({wr_ptr, rd_ptr} !== 10'd0) begin bad++; $display("FAIL mid_ptrs: got %0h/%0h want 0/0", wr_ptr, rd_ptr); end
    total++; if ({wr_greenflag, rd_greenflag, used_lines} !== {1'b1, 1'b0, 3'd0}) begin bad++; $display("FAIL mid_occ: got %b want 10000", {wr_greenflag, rd_greenflag, used_lines}); end
    total++; if ({wr_afull, tlast_flag, rd_line_len, rd_last_char, wr_drop} !== 8'd0) begin bad++; $display("FAIL mid_flags: got %b want 0", {wr_afull, tlast_flag, rd_line_len, rd_last_char, wr_drop}); end
  endtask

  initial begin
    rst = 1'b1;
    wr_char_incr = 1'b0; wr_newline = 1'b0; wr_restart_line = 1'b0; wr_tlast = 1'b0;
    rd_char_incr = 1'b0; rd_newline = 1'b0; rd_restart_line = 1'b0;
    test_reset();
    test_basic_line();
    test_fill();
    test_back_to_back();
    test_overflow();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
